// File: rtl/mips_data_mem_arbiter.sv
// mips_data_mem_arbiter: round-robin CPU/loader arbiter for one shared data memory port.
// Define MEM_ARB_CPU_PRIORITY_EN to make the CPU win every tie (loader may starve).
module mips_data_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  input  logic        ldr_read,
  input  logic        ldr_write,
  input  logic [31:0] ldr_address,
  input  logic [31:0] ldr_writedata,
  output logic [31:0] ldr_readdata,
  output logic        ldr_stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;
  logic owner, last_owner, op_write, cpu_req, ldr_req, win, rd_done;
  logic [31:0] cpu_rd_q, ldr_rd_q;
  // owner/last_owner/win: 0 = CPU, 1 = loader
  always_comb begin
    cpu_req = cpu_read | cpu_write;
    ldr_req = ldr_read | ldr_write;
`ifdef MEM_ARB_CPU_PRIORITY_EN
    win = ~cpu_req;
`else
    win = ldr_req & (~cpu_req | ~last_owner);
`endif
    rd_done = state == DONE && !op_write && !reset;
    mem_read = state == ISSUE && clk_enable && !reset && !op_write;
    mem_write = state == ISSUE && clk_enable && !reset && op_write;
    // memory data arrives during DONE; bypass it so readdata is valid in DONE, register it on exit
    cpu_readdata = rd_done && !owner ? mem_readdata : cpu_rd_q;
    ldr_readdata = rd_done && owner ? mem_readdata : ldr_rd_q;
    cpu_stall = cpu_req && (reset || state != DONE || owner);
    ldr_stall = ldr_req && (reset || state != DONE || !owner);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last_owner <= 1'b1;
      op_write <= 1'b0;
      mem_address <= '0;
      mem_writedata <= '0;
      cpu_rd_q <= '0;
      ldr_rd_q <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: if (cpu_req || ldr_req) begin
          state <= ISSUE;
          owner <= win;
          last_owner <= win;
          op_write <= win ? ldr_write : cpu_write;
          mem_address <= win ? ldr_address : cpu_address;
          mem_writedata <= win ? ldr_writedata : cpu_writedata;
        end
        ISSUE: state <= DONE;
        DONE: begin
          state <= IDLE;
          if (!op_write && !owner) cpu_rd_q <= mem_readdata;
          if (!op_write && owner) ldr_rd_q <= mem_readdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// tb_mips_data_mem_arbiter: vector table, directed corner sequences and random traffic
// checked against a serialized reference memory.
module tb_mips_data_mem_arbiter;
`ifdef MEM_ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam logic [31:0] D = 32'hDEADBEEF;
  logic clk = 1'b0, reset, clk_enable;
  logic cpu_read, cpu_write, cpu_stall, ldr_read, ldr_write, ldr_stall, mem_read, mem_write;
  logic [31:0] cpu_address, cpu_writedata, cpu_readdata, ldr_address, ldr_writedata, ldr_readdata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic [31:0] mem [16];
  int total = 0, passed = 0;
  mips_data_mem_arbiter dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_stall(cpu_stall),
    .ldr_read(ldr_read), .ldr_write(ldr_write), .ldr_address(ldr_address),
    .ldr_writedata(ldr_writedata), .ldr_readdata(ldr_readdata), .ldr_stall(ldr_stall),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_readdata(mem_readdata)
  );
  always #5 clk = ~clk;
  // synchronous memory: read data appears the cycle after mem_read
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
      mem_readdata <= '0;
    end else begin
      if (mem_write) mem[mem_address[5:2]] <= mem_writedata;
      if (mem_read) mem_readdata <= mem[mem_address[5:2]];
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic chk1(input string n, input logic act, input logic exp);
    chk(n, {31'b0, act}, {31'b0, exp});
  endtask
  task automatic chk_wait(input string n, input int w);
    total++;
    if (w <= 6) passed++;
    else $display("FAIL %s: waited %0d cycles, limit 6", n, w);
  endtask
  task automatic idle_in();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;
    ldr_read = 1'b0; ldr_write = 1'b0; ldr_address = '0; ldr_writedata = '0;
  endtask
  task automatic rst_cycle();
    idle_in();
    reset = 1'b1; clk_enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  typedef struct {
    logic rst, ce, cr, cw; logic [31:0] ca, cwd; logic lr, lw; logic [31:0] la;
    logic cs, ls, mr, mw; logic [31:0] ma, mwd, crd, lrd;
  } vec_t;
  vec_t tbl[16];
  logic [31:0] q[$];
  logic [31:0] ref_mem [16];
  logic act[2], rb[2], wb[2], stl[2];
  logic [3:0] ai[2];
  logic [31:0] wd[2], rdv[2], exp_rd[2];
  int waitc[2];
  logic [1:0] rw;
  initial begin
    //         rst ce  cr  cw  ca     cwd lr  lw  la      cs  ls  mr  mw  ma     mwd crd        lrd
    tbl[0]  = '{'1,'1,'1,'0,'0,    '0,'0,'1,'0,     '1,'1,'0,'0,'0,    '0,'0,       '0};
    tbl[1]  = '{'0,'1,'0,'1,32'h4, D, '0,'0,'0,     '1,'0,'0,'0,'0,    '0,'0,       '0};
    tbl[2]  = '{'0,'1,'0,'1,32'h4, D, '0,'0,'0,     '1,'0,'0,'1,32'h4, D, '0,       '0};
    tbl[3]  = '{'0,'1,'0,'1,32'h4, D, '0,'0,'0,     '0,'0,'0,'0,32'h4, D, '0,       '0};
    tbl[4]  = '{'0,'1,'1,'0,32'h4, '0,'0,'0,'0,     '1,'0,'0,'0,32'h4, D, '0,       '0};
    tbl[5]  = '{'0,'1,'1,'0,32'h4, '0,'0,'0,'0,     '1,'0,'1,'0,32'h4, '0,'0,       '0};
    tbl[6]  = '{'0,'1,'1,'0,32'h4, '0,'0,'0,'0,     '0,'0,'0,'0,32'h4, '0,D,        '0};
    tbl[7]  = '{'0,'1,'0,'0,'0,    '0,'0,'0,'0,     '0,'0,'0,'0,32'h4, '0,D,        '0};
    tbl[8]  = '{'1,'1,'0,'0,'0,    '0,'0,'0,'0,     '0,'0,'0,'0,32'h4, '0,D,        '0};
    tbl[9]  = '{'0,'1,'1,'0,32'hC, '0,'1,'0,32'h8,  '1,'1,'0,'0,'0,    '0,'0,       '0};
    tbl[10] = '{'0,'1,'1,'0,32'hC, '0,'1,'0,32'h8,  '1,'1,'1,'0,32'hC, '0,'0,       '0};
    tbl[11] = '{'0,'1,'1,'0,32'hC, '0,'1,'0,32'h8,  '0,'1,'0,'0,32'hC, '0,32'h1003, '0};
    tbl[12] = '{'0,'1,'0,'0,'0,    '0,'1,'0,32'h8,  '0,'1,'0,'0,32'hC, '0,32'h1003, '0};
    tbl[13] = '{'0,'1,'0,'0,'0,    '0,'1,'0,32'h8,  '0,'1,'1,'0,32'h8, '0,32'h1003, '0};
    tbl[14] = '{'0,'1,'0,'0,'0,    '0,'1,'0,32'h8,  '0,'0,'0,'0,32'h8, '0,32'h1003, 32'h1002};
    tbl[15] = '{'0,'1,'0,'0,'0,    '0,'0,'0,'0,     '0,'0,'0,'0,32'h8, '0,32'h1003, 32'h1002};
    idle_in();
    reset = 1'b1; clk_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst; clk_enable = tbl[i].ce;
      cpu_read = tbl[i].cr; cpu_write = tbl[i].cw; cpu_address = tbl[i].ca; cpu_writedata = tbl[i].cwd;
      ldr_read = tbl[i].lr; ldr_write = tbl[i].lw; ldr_address = tbl[i].la; ldr_writedata = '0;
      @(negedge clk);
      chk1($sformatf("row%0d cpu_stall", i), cpu_stall, tbl[i].cs);
      chk1($sformatf("row%0d ldr_stall", i), ldr_stall, tbl[i].ls);
      chk1($sformatf("row%0d mem_read", i), mem_read, tbl[i].mr);
      chk1($sformatf("row%0d mem_write", i), mem_write, tbl[i].mw);
      chk($sformatf("row%0d mem_address", i), mem_address, tbl[i].ma);
      chk($sformatf("row%0d mem_writedata", i), mem_writedata, tbl[i].mwd);
      chk($sformatf("row%0d cpu_readdata", i), cpu_readdata, tbl[i].crd);
      chk($sformatf("row%0d ldr_readdata", i), ldr_readdata, tbl[i].lrd);
      @(posedge clk); #1;
    end
    // continuous requests from both: grant order
    rst_cycle();
    cpu_read = 1'b1; cpu_address = 32'h20; ldr_read = 1'b1; ldr_address = 32'h24;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (mem_read) q.push_back(mem_address);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant%0d", k), q.size() > k ? q[k] : 32'hxxxxxxxx,
          (PRIO || k % 2 == 0) ? 32'h20 : 32'h24);
    // clock enable low during ISSUE
    rst_cycle();
    ldr_read = 1'b1; ldr_address = 32'h10;
    @(posedge clk); #1;
    clk_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("freeze%0d mem_read", k), mem_read, 1'b0);
      chk1($sformatf("freeze%0d ldr_stall", k), ldr_stall, 1'b1);
      chk($sformatf("freeze%0d mem_address", k), mem_address, 32'h10);
      @(posedge clk); #1;
    end
    clk_enable = 1'b1;
    @(negedge clk);
    chk1("thaw mem_read", mem_read, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("thaw done ldr_stall", ldr_stall, 1'b0);
    chk("thaw done ldr_readdata", ldr_readdata, 32'h1004);
    @(posedge clk); #1;
    ldr_read = 1'b0;
    @(negedge clk);
    chk("thaw held ldr_readdata", ldr_readdata, 32'h1004);
    // reset during ISSUE of a loader read
    rst_cycle();
    ldr_read = 1'b1; ldr_address = 32'h14;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort issue mem_read", mem_read, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort in-reset mem_read", mem_read, 1'b0);
    chk1("abort in-reset ldr_stall", ldr_stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("abort idle ldr_stall", ldr_stall, 1'b1);
    chk1("abort idle mem_read", mem_read, 1'b0);
    chk("abort idle ldr_readdata", ldr_readdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort retry mem_read", mem_read, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort retry ldr_readdata", ldr_readdata, 32'h1005);
    // random traffic against a serialized reference memory
    rst_cycle();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000 + i;
    for (int s = 0; s < 2; s++) begin
      act[s] = 1'b0; rb[s] = 1'b0; wb[s] = 1'b0; ai[s] = '0; wd[s] = '0; exp_rd[s] = '0; waitc[s] = 0;
    end
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      stl[0] = cpu_stall; stl[1] = ldr_stall; rdv[0] = cpu_readdata; rdv[1] = ldr_readdata;
      if (mem_read || mem_write) chk1("rand mem strobes exclusive", mem_read & mem_write, 1'b0);
      for (int s = 0; s < 2; s++) if (act[s] && clk_enable) begin
        waitc[s]++;
        if (!stl[s]) begin
          if (wb[s]) ref_mem[ai[s]] = wd[s];
          else begin
            chk($sformatf("rand readdata%0d", s), rdv[s], ref_mem[ai[s]]);
            exp_rd[s] = ref_mem[ai[s]];
          end
          chk($sformatf("rand other readdata%0d", 1 - s), rdv[1 - s], exp_rd[1 - s]);
          if (s == 0 || !PRIO) chk_wait($sformatf("rand wait%0d", s), waitc[s]);
          act[s] = 1'b0;
        end
      end
      for (int s = 0; s < 2; s++) if (!act[s] && $urandom_range(0, 2) != 0) begin
        rw = 2'($urandom_range(1, 3));
        act[s] = 1'b1; rb[s] = rw[0]; wb[s] = rw[1];
        ai[s] = 4'($urandom_range(0, 15)); wd[s] = $urandom; waitc[s] = 0;
      end
      cpu_read = act[0] & rb[0]; cpu_write = act[0] & wb[0];
      cpu_address = {26'b0, ai[0], 2'b0}; cpu_writedata = wd[0];
      ldr_read = act[1] & rb[1]; ldr_write = act[1] & wb[1];
      ldr_address = {26'b0, ai[1], 2'b0}; ldr_writedata = wd[1];
      clk_enable = $urandom_range(0, 5) != 0;
      @(negedge clk);
    end
    for (int s = 0; s < 2; s++)
      if (act[s] && (s == 0 || !PRIO)) chk_wait($sformatf("final wait%0d", s), waitc[s]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
